// File: rtl/instr_dispatch_pkg.sv
// Shared constants for the instruction dispatcher: opcodes, FSM states,
// cmd_word field layout and frame geometry.
package instr_dispatch_pkg;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int OP_W    = 3;
  localparam int ZOOM_W  = 3;
  localparam int FRAME_W = 320;
  localparam int FRAME_H = 240;
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);

  localparam logic [ZOOM_W-1:0] ZOOM_RESET = 3'd4;
  localparam logic [ZOOM_W-1:0] ZOOM_MIN   = 3'd2;
  localparam logic [ZOOM_W-1:0] ZOOM_MAX   = 3'd6;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_RD  = 3'b001;
  localparam logic [OP_W-1:0] OP_WR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NHI = 3'b011;
  localparam logic [OP_W-1:0] OP_PR  = 3'b100;
  localparam logic [OP_W-1:0] OP_NH  = 3'b101;
  localparam logic [OP_W-1:0] OP_BA  = 3'b110;
  localparam logic [OP_W-1:0] OP_RSV = 3'b111;

  localparam int CMD_OP_LSB   = 0;
  localparam int CMD_ADDR_LSB = 3;
  localparam int CMD_COL_LSB  = 20;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode classification and validation (reserved opcode,
// out-of-frame address, zoom limits) for the latched instruction.
module instr_decode
  import instr_dispatch_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ZOOM_W-1:0] zoom_i,
  output logic              is_nop_o,
  output logic              is_read_o,
  output logic              is_zoom_in_o,
  output logic              is_zoom_out_o,
  output logic              error_o
);

  logic is_mem;
  logic bad_addr;

  always_comb begin
    is_nop_o      = (op_i == OP_NOP);
    is_read_o     = (op_i == OP_RD);
    is_mem        = (op_i == OP_RD) || (op_i == OP_WR);
    is_zoom_in_o  = (op_i == OP_NHI) || (op_i == OP_PR);
    is_zoom_out_o = (op_i == OP_NH) || (op_i == OP_BA);
    bad_addr      = is_mem && (addr_i > MAX_ADDR);
    error_o       = (op_i == OP_RSV) || bad_addr
                  || (is_zoom_in_o  && (zoom_i == ZOOM_MAX))
                  || (is_zoom_out_o && (zoom_i == ZOOM_MIN));
  end

endmodule

// File: rtl/instr_dispatch.sv
// Instruction front-end for memory control: accept, validate, issue, wait for
// done, respond. Optional stats ports enabled by INSTR_DISPATCH_STATS_EN.
module instr_dispatch
  import instr_dispatch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [31:0]       cmd_word,
  output logic              cmd_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              mc_enable,
  output logic [OP_W-1:0]   mc_operation,
  output logic [ADDR_W-1:0] mc_addr_base,
  output logic [DATA_W-1:0] mc_color_wr,
  output logic [ZOOM_W-1:0] mc_zoom,
  input  logic              mc_done,
  input  logic [DATA_W-1:0] mc_color_rd,
  output logic              busy
`ifdef INSTR_DISPATCH_STATS_EN
  ,
  output logic [23:0]       last_cycles,
  output logic [15:0]       cmd_count
`endif
);

  state_e              state_q;
  logic                cmd_ready_q, rsp_valid_q, rsp_error_q, mc_enable_q;
  logic [DATA_W-1:0]   rsp_data_q, mc_color_q, col_q;
  logic [OP_W-1:0]     mc_operation_q, op_q;
  logic [ADDR_W-1:0]   mc_addr_q, addr_q;
  logic [ZOOM_W-1:0]   mc_zoom_q, zoom_d;
  logic                dec_nop, dec_read, dec_zin, dec_zout, dec_err;
  logic                unused_hi;

  assign unused_hi = ^cmd_word[31:28];

  instr_decode u_decode (
    .op_i          (op_q),
    .addr_i        (addr_q),
    .zoom_i        (mc_zoom_q),
    .is_nop_o      (dec_nop),
    .is_read_o     (dec_read),
    .is_zoom_in_o  (dec_zin),
    .is_zoom_out_o (dec_zout),
    .error_o       (dec_err)
  );

  always_comb begin
    zoom_d = mc_zoom_q;
    if (dec_zin)       zoom_d = mc_zoom_q + 3'd1;
    else if (dec_zout) zoom_d = mc_zoom_q - 3'd1;
  end

  // mc_* bundle is only rewritten on issue so memory control sees it stable
  // for the whole operation and through the response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cmd_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_error_q    <= 1'b0;
      mc_enable_q    <= 1'b0;
      mc_operation_q <= '0;
      mc_addr_q      <= '0;
      mc_color_q     <= '0;
      mc_zoom_q      <= ZOOM_RESET;
      op_q           <= '0;
      addr_q         <= '0;
      col_q          <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_word[CMD_OP_LSB +: OP_W];
            addr_q      <= cmd_word[CMD_ADDR_LSB +: ADDR_W];
            col_q       <= cmd_word[CMD_COL_LSB +: DATA_W];
            cmd_ready_q <= 1'b0;
            state_q     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dec_err || dec_nop) begin
            rsp_error_q <= dec_err;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            mc_enable_q    <= 1'b1;
            mc_operation_q <= op_q;
            mc_addr_q      <= addr_q;
            mc_color_q     <= col_q;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mc_enable_q <= 1'b0;
          state_q     <= S_WAIT_ACK;
        end
        // done is still at its idle-high level right after enable
        S_WAIT_ACK: begin
          if (!mc_done) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (mc_done) begin
            rsp_data_q  <= dec_read ? mc_color_rd : '0;
            rsp_error_q <= 1'b0;
            mc_zoom_q   <= zoom_d;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_error    = rsp_error_q;
  assign mc_enable    = mc_enable_q;
  assign mc_operation = mc_operation_q;
  assign mc_addr_base = mc_addr_q;
  assign mc_color_wr  = mc_color_q;
  assign mc_zoom      = mc_zoom_q;
  assign busy         = (state_q != S_IDLE);

`ifdef INSTR_DISPATCH_STATS_EN
  logic [23:0] cyc_q, cyc_d, last_q;
  logic [15:0] cnt_q;

  assign cyc_d = (&cyc_q) ? cyc_q : cyc_q + 24'd1;

  // cyc_q counts cycles spent in S_ISSUE..S_WAIT_DONE of the current op
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && cmd_valid && cmd_ready_q) cnt_q <= cnt_q + 16'd1;
      case (state_q)
        S_CHECK:                 cyc_q <= '0;
        S_ISSUE, S_WAIT_ACK:     cyc_q <= cyc_d;
        S_WAIT_DONE: begin
          cyc_q <= cyc_d;
          if (mc_done) last_q <= cyc_d;
        end
        default: ;
      endcase
    end
  end

  assign last_cycles = last_q;
  assign cmd_count   = cnt_q;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed steps then random commands
// against a rule-level reference model and a behavioural memory-control model.
`timescale 1ns/1ps
module tb_instr_dispatch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] cmd_word = '0;
  logic        cmd_ready, rsp_valid, rsp_error, mc_enable, busy;
  logic [7:0]  rsp_data, mc_color_wr;
  logic [2:0]  mc_operation, mc_zoom;
  logic [16:0] mc_addr_base;
  logic        mc_done = 1'b1;
  logic [7:0]  mc_color_rd = '0;
`ifdef INSTR_DISPATCH_STATS_EN
  logic [23:0] last_cycles;
  logic [15:0] cmd_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instr_dispatch dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_word     (cmd_word),
    .cmd_ready    (cmd_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .mc_enable    (mc_enable),
    .mc_operation (mc_operation),
    .mc_addr_base (mc_addr_base),
    .mc_color_wr  (mc_color_wr),
    .mc_zoom      (mc_zoom),
    .mc_done      (mc_done),
    .mc_color_rd  (mc_color_rd),
    .busy         (busy)
`ifdef INSTR_DISPATCH_STATS_EN
    ,
    .last_cycles  (last_cycles),
    .cmd_count    (cmd_count)
`endif
  );

  // Memory-control model: done idles high, stays high a few stale cycles after
  // enable, drops for a random duration, then rises with the read colour.
  bit [7:0]    mm [0:131071];
  logic        mb = 1'b0, en_prev = 1'b0, long_dur = 1'b0;
  logic [2:0]  mop = '0;
  logic [16:0] ma = '0;
  logic [7:0]  mcol = '0;
  int          stale = 0, dur = 0, en_cnt = 0, en_bad = 0;

  always @(posedge clock) begin
    en_prev <= mc_enable && !reset;
    if (mc_enable && en_prev) en_bad <= en_bad + 1;
    if (mc_enable) en_cnt <= en_cnt + 1;
    if (reset) begin
      mb      <= 1'b0;
      mc_done <= 1'b1;
      stale   <= 0;
      dur     <= 0;
    end else if (mc_enable) begin
      mb    <= 1'b1;
      mop   <= mc_operation;
      ma    <= mc_addr_base;
      mcol  <= mc_color_wr;
      stale <= $urandom_range(0, 2);
      dur   <= long_dur ? 20 : $urandom_range(1, 6);
    end else if (mb) begin
      if (stale > 0) stale <= stale - 1;
      else if (dur > 0) begin
        mc_done <= 1'b0;
        dur     <= dur - 1;
      end else begin
        mc_done <= 1'b1;
        mb      <= 1'b0;
        if (mop == 3'd2) mm[ma] <= mcol;
        mc_color_rd <= (mop == 3'd1) ? mm[ma] : 8'($urandom);
      end
    end
  end

  // Reference model state
  bit [7:0] ref_mem [0:131071];
  int       ref_zoom = 4;
  int       pool [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_outs_a", {cmd_ready, rsp_valid, rsp_data, rsp_error, mc_enable,
                       mc_operation, mc_addr_base}, 32'h8000_0000);
    chk("rst_outs_b", {20'd0, mc_color_wr, mc_zoom, busy}, {20'd0, 8'd0, 3'd4, 1'b0});
  endtask

  task automatic do_cmd(input int op, input int addr, input logic [7:0] col, input int hold);
    int          lat;
    bit          exp_e, mem, stable, held;
    logic [7:0]  exp_d;
    logic [16:0] a17;
    int          en0;
    a17   = addr[16:0];
    exp_e = (op == 7) || ((op == 1 || op == 2) && addr > 76799)
         || ((op == 3 || op == 4) && ref_zoom == 6)
         || ((op == 5 || op == 6) && ref_zoom == 2);
    mem   = !exp_e && op != 0;
    exp_d = (!exp_e && op == 1) ? ref_mem[addr] : 8'd0;

    lat = 0;
    while (cmd_ready !== 1'b1 && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    en0       = en_cnt;
    cmd_valid = 1'b1;
    cmd_word  = {4'($urandom), col, a17, 3'(op)};
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_word  = $urandom;
    lat    = 1;
    stable = 1;
    while (rsp_valid !== 1'b1 && lat < 300) begin
      if (mem && lat >= 2)
        stable &= (mc_operation === 3'(op)) && (mc_addr_base === a17) && (mc_color_wr === col);
      @(negedge clock);
      lat++;
    end
    chk("rsp_arrives", rsp_valid, 1);
    if (!mem) chk("short_latency", lat, 2);
    held = 1;
    for (int i = 0; i < hold; i++) begin
      held &= (rsp_valid === 1'b1) && (cmd_ready === 1'b0) && (busy === 1'b1);
      if (mem) stable &= (mc_operation === 3'(op)) && (mc_addr_base === a17);
      @(negedge clock);
    end
    if (hold > 0) chk("rsp_held", held, 1);
    if (mem) chk("mc_stable", stable, 1);
    chk("rsp_error", rsp_error, exp_e);
    chk("rsp_data", rsp_data, exp_d);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("post_rsp", {cmd_ready, busy, rsp_valid}, 3'b100);
    chk("enable_pulses", en_cnt - en0, mem ? 1 : 0);
    chk("enable_width", en_bad, 0);
    if (!exp_e) begin
      if (op == 2) ref_mem[addr] = col;
      if (op == 3 || op == 4) ref_zoom++;
      if (op == 5 || op == 6) ref_zoom--;
    end
    chk("zoom", mc_zoom, ref_zoom);
  endtask

  initial begin
    pool[0] = 0;   pool[1] = 1;     pool[2] = 100;   pool[3] = 76799;
    pool[4] = 319; pool[5] = 40000; pool[6] = 76798; pool[7] = 12345;

    repeat (3) @(negedge clock);
    chk_reset();
    reset = 1'b0;
    @(negedge clock);

    do_cmd(2, 100, 8'hAB, 0);       // WR
    do_cmd(1, 100, 8'h00, 2);       // RD back 0xAB
    do_cmd(1, 76800, 8'h00, 0);     // out of frame
    do_cmd(0, 5, 8'h11, 0);         // NOP
    do_cmd(3, 0, 8'h00, 0);         // zoom 5
    do_cmd(3, 0, 8'h00, 0);         // zoom 6
    do_cmd(3, 0, 8'h00, 0);         // at max -> error
    do_cmd(6, 0, 8'h00, 0);         // zoom 5
    do_cmd(5, 0, 8'h00, 0);         // 4
    do_cmd(6, 0, 8'h00, 0);         // 3
    do_cmd(5, 0, 8'h00, 0);         // 2
    do_cmd(6, 0, 8'h00, 0);         // at min -> error
    do_cmd(4, 0, 8'h00, 0);         // 3
    do_cmd(7, 0, 8'h00, 10);        // reserved, held response

    // Reset while memory control is mid-operation
    long_dur  = 1'b1;
    cmd_valid = 1'b1;
    cmd_word  = {4'd0, 8'h77, 17'd5, 3'd2};
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (10) @(negedge clock);
    chk("busy_pre_rst", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    chk_reset();
    reset    = 1'b0;
    long_dur = 1'b0;
    ref_zoom = 4;
    @(negedge clock);
    do_cmd(2, 200, 8'h5C, 0);
    do_cmd(1, 5, 8'h00, 0);         // abandoned write left no trace
    do_cmd(1, 200, 8'h00, 0);

    for (int n = 0; n < 80; n++) begin
      int op, addr;
      op   = $urandom_range(0, 7);
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(76800, 131071)
                                         : pool[$urandom_range(0, 7)];
      do_cmd(op, addr, 8'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
